// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its PLL / reset consumers.
// The slave side is the supervisor; the master side drives pll_locked and restart.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [7:0] retry_count;

    modport master (
        output pll_locked, restart,
        input  pll_rst, sys_rst, ready, fail, lock_lost, retry_count
    );

    modport slave (
        input  pll_locked, restart,
        output pll_rst, sys_rst, ready, fail, lock_lost, retry_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for a qualified lock with timeout/retry,
// then releases sys_rst. Runs on the PLL reference clock, never on PLL outputs.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES         = 2,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.slave  bus,
    output logic [2:0]            dbg_state_o
);
    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                       : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIM   = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PRST      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             retry_q, retry_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   pll_rst_q, sys_rst_q, ready_q, fail_q;
    logic                   lk;
    logic [7:0]             retry_inc;
    logic                   attempt_fail;

    assign lk = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        lock_lost_d  = lock_lost_q;
        attempt_fail = 1'b0;
        retry_inc    = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;

        case (state_q)
            S_PRST:      if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            // A lock seen in the timeout cycle still counts as a lock.
            S_WAIT_LOCK: if (lk) state_d = S_STABLE;
                         else if (cnt_q == TO_LAST) attempt_fail = 1'b1;
            S_STABLE:    if (!lk) attempt_fail = 1'b1;
                         else if (cnt_q == STABLE_LAST) state_d = S_RUN;
            S_RUN:       if (!lk) begin
                             state_d     = S_PRST;
                             lock_lost_d = 1'b1;
                             retry_d     = 8'd0;
                         end
            S_FAIL:      state_d = S_FAIL;
            default:     state_d = S_PRST;
        endcase

        if (attempt_fail) begin
            retry_d = retry_inc;
            state_d = (MAX_RETRIES != 0 && retry_inc == RETRY_LIM) ? S_FAIL : S_PRST;
        end

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == S_PRST || state_q == S_WAIT_LOCK || state_q == S_STABLE)
            cnt_d = cnt_q + 1'b1;

        // restart overrides every transition computed above, including a lock drop in RUN.
        if (bus.restart) begin
            state_d     = S_PRST;
            cnt_d       = '0;
            retry_d     = 8'd0;
            lock_lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PRST;
            cnt_q       <= '0;
            sync_q      <= '0;
            retry_q     <= 8'd0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            // Outputs decode the next state so they move on the transition edge.
            pll_rst_q   <= (state_d == S_PRST) || (state_d == S_FAIL);
            sys_rst_q   <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.ready       = ready_q;
    assign bus.fail        = fail_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a retry-limited instance driven through its sequences and
// a retry-forever instance left unlocked to check saturation.
module tb_pll_lock_supervisor;
    logic       clk;
    logic       rst_a_n;
    logic       rst_b_n;
    logic [2:0] dbg_a;
    logic [2:0] dbg_b;
    int         tests_run = 0;
    int         failures  = 0;
    int         cyc       = 0;
    bit         fail_seen_b = 1'b0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    localparam logic [31:0] RST_OUTS = {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    pll_lock_supervisor_if ifa ();
    pll_lock_supervisor_if ifb ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
        .SYNC_STAGES(2), .MAX_RETRIES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(ifa), .dbg_state_o(dbg_a)
    );

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
        .SYNC_STAGES(2), .MAX_RETRIES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(ifb), .dbg_state_o(dbg_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (rst_b_n && ifb.fail) fail_seen_b = 1'b1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            check_eq(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    function automatic logic [31:0] outs_a();
        return {19'd0, ifa.pll_rst, ifa.sys_rst, ifa.ready, ifa.fail, ifa.lock_lost,
                ifa.retry_count};
    endfunction

    // driver tasks
    task automatic level_len(input logic lvl, output int n);
        n = 0;
        while (ifa.pll_rst === lvl && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ifa.ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_restart();
        ifa.restart = 1'b1;
        @(negedge clk);
        ifa.restart = 1'b0;
    endtask

    initial begin
        int n;
        bit saw_prst;
        bit saw_ready;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ifa.pll_locked = 1'b1;
        ifa.restart    = 1'b0;
        ifb.pll_locked = 1'b0;
        ifb.restart    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs_a", outs_a(), RST_OUTS);
        check_eq("reset_retry_b", ifb.retry_count, 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Locked from the start: one 4-cycle pulse, then RUN.
        sb_push("first_pulse_len", 4);
        level_len(1'b1, n);
        sb_pop(n);
        wait_ready(n);
        check_eq("ready_latency_window", (n >= 9 && n <= 11), 1);
        check_eq("run_sys_rst", ifa.sys_rst, 0);
        check_eq("run_retry", ifa.retry_count, 0);

        // Lock drop in RUN.
        ifa.pll_locked = 1'b0;
        n = 0;
        while (ifa.sys_rst !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("run_drop_latency", (n >= 2 && n <= 3), 1);
        check_eq("run_drop_outs", outs_a(), {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
        ifa.pll_locked = 1'b1;
        wait_ready(n);
        check_eq("relock_ready", ifa.ready, 1);
        check_eq("relock_lock_lost_sticky", ifa.lock_lost, 1);

        pulse_restart();
        check_eq("restart_from_run", outs_a(), RST_OUTS);

        // Still locked: drop lk for one cycle while STABLE is at count 5.
        repeat (8) @(negedge clk);
        ifa.pll_locked = 1'b0;
        @(negedge clk);
        ifa.pll_locked = 1'b1;
        saw_prst  = 1'b0;
        saw_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.pll_rst) saw_prst = 1'b1;
            if (ifa.ready) saw_ready = 1'b1;
        end
        check_eq("stable_drop_prst", saw_prst, 1);
        check_eq("stable_drop_no_ready", saw_ready, 0);
        check_eq("stable_drop_retry", ifa.retry_count, 1);
        wait_ready(n);
        check_eq("stable_drop_then_run", ifa.ready, 1);

        // Never locks: two attempts, then FAIL.
        ifa.pll_locked = 1'b0;
        pulse_restart();
        sb_push("nolock_pulse1", 4);
        sb_push("nolock_wait1", 20);
        sb_push("nolock_pulse2", 4);
        sb_push("nolock_wait2", 20);
        level_len(1'b1, n); sb_pop(n);
        level_len(1'b0, n); sb_pop(n);
        check_eq("retry_after_first_timeout", ifa.retry_count, 1);
        level_len(1'b1, n); sb_pop(n);
        level_len(1'b0, n); sb_pop(n);
        check_eq("fail_outs", outs_a(), {19'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2});
        repeat (30) @(negedge clk);
        check_eq("fail_terminal", outs_a(), {19'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2});
        pulse_restart();
        check_eq("restart_from_fail", outs_a(), RST_OUTS);

        // Asynchronous reset in WAIT_LOCK, then in RUN.
        level_len(1'b1, n);
        repeat (5) @(negedge clk);
        #2 rst_a_n = 1'b0;
        #1 check_eq("async_rst_wait", outs_a(), RST_OUTS);
        @(negedge clk);
        rst_a_n = 1'b1;
        ifa.pll_locked = 1'b1;
        wait_ready(n);
        check_eq("ready_after_reset", ifa.ready, 1);
        #2 rst_a_n = 1'b0;
        #1 check_eq("async_rst_run", outs_a(), RST_OUTS);
        @(negedge clk);
        rst_a_n = 1'b1;

        // Retry-forever instance: ~300 attempts of 24 cycles with no lock.
        while (cyc < 7500) @(negedge clk);
        check_eq("retry_saturated", ifb.retry_count, 255);
        check_eq("retry_forever_no_fail", fail_seen_b, 0);

        check_eq("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
